dfd_cla_counter_csr: RTL and testbench

Register slice that terminates the CLA counter write-back path and owns the counter configuration/state CSR. It receives the per-cycle hardware update (counter low/high halves plus write enables) from the CLA counter engine and the software accesses from the 16-bit debug CSR bus. It drives the current counter, target and ResetOnTarget values back to the engine. Reads of the wide counter are coherent through a snapshot; software writes of the wide counter are atomic through a shadow.

---
 rtl/dfd_cla_pkg.sv | 18 +
 rtl/dfd_cla_csr_rsp_slot.sv | 27 ++
 rtl/dfd_cla_counter_csr.sv | 101 ++++++++++
 tb/tb_dfd_cla_counter_csr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dfd_cla_pkg.sv
// dfd_cla_pkg: shared CSR addresses, control bit position and field bundle for the CLA counter CSR.
package dfd_cla_pkg;

    localparam logic [1:0] CLA_CNT_LO = 2'd0;
    localparam logic [1:0] CLA_CNT_HI = 2'd1;
    localparam logic [1:0] CLA_TGT_LO = 2'd2;
    localparam logic [1:0] CLA_TGT_HI = 2'd3;

    localparam int CLA_RST_ON_TGT_BIT = 15;

    typedef struct packed {
        logic [15:0] counter_lo;
        logic [15:0] target_lo;
        logic [15:0] shadow_lo;
        logic        reset_on_target;
    } cla_csr_lo_t;

endpackage

// File: rtl/dfd_cla_csr_rsp_slot.sv
// dfd_cla_csr_rsp_slot: single-entry valid/ready holding register for CSR responses.
module dfd_cla_csr_rsp_slot (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        rsp_ready,
    output logic        load_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata
);

    assign load_ready = !rsp_valid | rsp_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dfd_cla_counter_csr.sv
// dfd_cla_counter_csr: CLA counter/target CSR with coherent wide reads via snapshot and atomic wide writes via shadow.
module dfd_cla_counter_csr
    import dfd_cla_pkg::*;
#(
    parameter int unsigned                COUNTER_WIDTH = 31,
    parameter logic [COUNTER_WIDTH-1:0]   RESET_TARGET  = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_addr,
    input  logic [15:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_rdata,
    input  logic                     hw_counter_wr_en,
    input  logic                     hw_upper_wr_en,
    input  logic [15:0]              hw_counter,
    input  logic [COUNTER_WIDTH-17:0] hw_upper_counter,
    output logic [15:0]              cfg_counter,
    output logic [COUNTER_WIDTH-17:0] cfg_upper_counter,
    output logic [15:0]              cfg_target,
    output logic [COUNTER_WIDTH-17:0] cfg_upper_target,
    output logic                     cfg_reset_on_target
);

    localparam int UW = COUNTER_WIDTH - 16;

    cla_csr_lo_t   csr;
    logic [UW-1:0] counter_hi;
    logic [UW-1:0] target_hi;
    logic [UW-1:0] snapshot;
    logic          accept;
    logic          wr;
    logic          rd;
    logic [15:0]   rdata;

    assign accept = req_valid & req_ready;
    assign wr     = accept & req_write;
    assign rd     = accept & ~req_write;

    always_comb
        rdata = req_write                ? 16'h0000 :
                req_addr == CLA_CNT_LO   ? csr.counter_lo :
                req_addr == CLA_CNT_HI   ? 16'(snapshot) :
                req_addr == CLA_TGT_LO   ? csr.target_lo :
                                           {csr.reset_on_target, 15'(target_hi)};

    // A software CNT_HI commit replaces both halves and drops any same-cycle hardware update.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            csr.counter_lo      <= '0;
            csr.target_lo       <= RESET_TARGET[15:0];
            csr.shadow_lo       <= '0;
            csr.reset_on_target <= 1'b0;
            counter_hi          <= '0;
            target_hi           <= RESET_TARGET[COUNTER_WIDTH-1:16];
            snapshot            <= '0;
        end else begin
            if (wr && req_addr == CLA_CNT_HI) begin
                counter_hi     <= req_wdata[UW-1:0];
                csr.counter_lo <= csr.shadow_lo;
            end else begin
                if (hw_counter_wr_en)
                    csr.counter_lo <= hw_counter;
                if (hw_upper_wr_en)
                    counter_hi <= hw_upper_counter;
            end
            if (wr && req_addr == CLA_CNT_LO)
                csr.shadow_lo <= req_wdata;
            if (wr && req_addr == CLA_TGT_LO)
                csr.target_lo <= req_wdata;
            if (wr && req_addr == CLA_TGT_HI) begin
                target_hi           <= req_wdata[UW-1:0];
                csr.reset_on_target <= req_wdata[CLA_RST_ON_TGT_BIT];
            end
            if (rd && req_addr == CLA_CNT_LO)
                snapshot <= counter_hi;
        end
    end

    dfd_cla_csr_rsp_slot u_rsp (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .load_data  (rdata),
        .rsp_ready  (rsp_ready),
        .load_ready (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata)
    );

    assign cfg_counter         = csr.counter_lo;
    assign cfg_upper_counter   = counter_hi;
    assign cfg_target          = csr.target_lo;
    assign cfg_upper_target    = target_hi;
    assign cfg_reset_on_target = csr.reset_on_target;

endmodule

// File: tb/tb_dfd_cla_counter_csr.sv
// tb_dfd_cla_counter_csr: directed and random stimulus against a flat arithmetic model of the counter CSR.
module tb_dfd_cla_counter_csr;

    localparam int                CW    = 31;
    localparam int                UW    = CW - 16;
    localparam logic [CW-1:0]     RT    = 31'h2ABC_DEF0;
    localparam int unsigned       HMASK = (32'd1 << UW) - 1;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_addr;
    logic [15:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_rdata;
    logic          hw_counter_wr_en;
    logic          hw_upper_wr_en;
    logic [15:0]   hw_counter;
    logic [UW-1:0] hw_upper_counter;
    logic [15:0]   cfg_counter;
    logic [UW-1:0] cfg_upper_counter;
    logic [15:0]   cfg_target;
    logic [UW-1:0] cfg_upper_target;
    logic          cfg_reset_on_target;

    dfd_cla_counter_csr #(.COUNTER_WIDTH(CW), .RESET_TARGET(RT)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .hw_counter_wr_en    (hw_counter_wr_en),
        .hw_upper_wr_en      (hw_upper_wr_en),
        .hw_counter          (hw_counter),
        .hw_upper_counter    (hw_upper_counter),
        .cfg_counter         (cfg_counter),
        .cfg_upper_counter   (cfg_upper_counter),
        .cfg_target          (cfg_target),
        .cfg_upper_target    (cfg_upper_target),
        .cfg_reset_on_target (cfg_reset_on_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int unsigned m_cnt, m_tgt, m_shadow, m_snap, m_data;
    bit          m_rot, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("cfg_counter", 32'({cfg_upper_counter, cfg_counter}), m_cnt);
        chk("cfg_target", 32'({cfg_upper_target, cfg_target}), m_tgt);
        chk("cfg_rot", 32'(cfg_reset_on_target), 32'(m_rot));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_rdata", 32'(rsp_rdata), m_data);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        hw_counter_wr_en = 1'b0;
        hw_upper_wr_en = 1'b0;
        m_cnt = 0; m_tgt = 32'(RT); m_shadow = 0; m_snap = 0; m_data = 0;
        m_rot = 1'b0; m_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_state();
        reset_n = 1'b1;
        #1 chk("ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    // Called at a falling edge: drive one cycle, advance the model, check after the next rising edge.
    task automatic cycle(input bit rv, input bit wr, input logic [1:0] a, input logic [15:0] wd,
                         input bit rr, input bit hwe, input bit hwue,
                         input logic [15:0] hw, input logic [UW-1:0] hwu);
        int unsigned rval;
        bit rdy, acc;
        req_valid = rv; req_write = wr; req_addr = a; req_wdata = wd; rsp_ready = rr;
        hw_counter_wr_en = hwe; hw_upper_wr_en = hwue; hw_counter = hw; hw_upper_counter = hwu;
        #1;
        rdy = !m_valid || rr;
        acc = rv && rdy;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        rval = 0;
        if (acc && !wr)
            case (a)
                2'd0:    rval = m_cnt & 32'hFFFF;
                2'd1:    rval = m_snap;
                2'd2:    rval = m_tgt & 32'hFFFF;
                default: rval = (32'(m_rot) << 15) | (m_tgt >> 16);
            endcase
        if (acc && !wr && a == 2'd0) m_snap = m_cnt >> 16;
        if (acc && wr && a == 2'd1) begin
            m_cnt = ((32'(wd) & HMASK) << 16) | m_shadow;
        end else begin
            if (hwe)  m_cnt = (m_cnt & 32'hFFFF_0000) | 32'(hw);
            if (hwue) m_cnt = (m_cnt & 32'hFFFF) | (32'(hwu) << 16);
        end
        if (acc && wr && a == 2'd0) m_shadow = 32'(wd);
        if (acc && wr && a == 2'd2) m_tgt = (m_tgt & 32'hFFFF_0000) | 32'(wd);
        if (acc && wr && a == 2'd3) begin
            m_tgt = (m_tgt & 32'hFFFF) | ((32'(wd) & HMASK) << 16);
            m_rot = wd[15];
        end
        if (acc) begin
            m_valid = 1'b1;
            m_data = rval;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        check_state();
    endtask

    task automatic rd(input logic [1:0] a, input bit rr);
        cycle(1'b1, 1'b0, a, 16'h0, rr, 1'b0, 1'b0, 16'h0, '0);
    endtask

    task automatic wrt(input logic [1:0] a, input logic [15:0] wd);
        cycle(1'b1, 1'b1, a, wd, 1'b1, 1'b0, 1'b0, 16'h0, '0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        hw_counter_wr_en = 1'b0; hw_upper_wr_en = 1'b0; hw_counter = '0; hw_upper_counter = '0;
        @(negedge clock);
        do_reset();

        rd(2'd0, 1'b1); chk("rst_cnt_lo", 32'(rsp_rdata), 32'h0000);
        rd(2'd1, 1'b1); chk("rst_cnt_hi", 32'(rsp_rdata), 32'h0000);
        rd(2'd2, 1'b1); chk("rst_tgt_lo", 32'(rsp_rdata), 32'hDEF0);
        rd(2'd3, 1'b1); chk("rst_tgt_hi", 32'(rsp_rdata), 32'h2ABC);

        wrt(2'd2, 16'h1234);
        wrt(2'd3, 16'h8005);
        chk("tgt_lo", 32'(cfg_target), 32'h1234);
        chk("tgt_hi", 32'(cfg_upper_target), 32'h5);
        chk("rot", 32'(cfg_reset_on_target), 32'h1);
        rd(2'd3, 1'b1); chk("rd_tgt_hi", 32'(rsp_rdata), 32'h8005);

        wrt(2'd0, 16'hFFFF);
        wrt(2'd1, 16'h0001);
        chk("cnt_commit", 32'({cfg_upper_counter, cfg_counter}), 32'h0001_FFFF);
        rd(2'd0, 1'b1); chk("rd_cnt_lo", 32'(rsp_rdata), 32'hFFFF);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0000, 15'h0002);
        chk("hw_update", 32'({cfg_upper_counter, cfg_counter}), 32'h0002_0000);
        rd(2'd1, 1'b1); chk("snap_coherent", 32'(rsp_rdata), 32'h0001);

        wrt(2'd0, 16'hBEEF);
        chk("shadow_only", 32'(cfg_counter), 32'h0000);
        cycle(1'b1, 1'b1, 2'd1, 16'h0042, 1'b1, 1'b1, 1'b0, 16'h0007, '0);
        chk("collision", 32'({cfg_upper_counter, cfg_counter}), 32'h0042_BEEF);

        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, '0);
        rd(2'd2, 1'b0); chk("stall_rsp0", 32'(rsp_rdata), 32'h1234);
        rd(2'd3, 1'b0); chk("stall_hold", 32'(rsp_rdata), 32'h1234);
        rd(2'd3, 1'b1); chk("stall_rsp1", 32'(rsp_rdata), 32'h8005);
        cycle(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, '0);

        rd(2'd0, 1'b0); chk("pend_before_rst", 32'(rsp_valid), 32'h1);
        do_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_counter", 32'({cfg_upper_counter, cfg_counter}), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom), UW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
